// File: rtl/fifo_reader.sv
// fifo_reader: pops a first-word-fall-through FIFO into a two-entry output stage, tagging every BURST-th word; define FIFO_READER_CNT_EN to add rd_count.
module fifo_reader #(
  parameter int WIDTH = 16,
  parameter int BURST = 4
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [15:0]      rd_count
`endif
);
  localparam int CW = $clog2(BURST) + 1;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic tag, load, sk_v, sk_l;
  logic [WIDTH-1:0] sk_d;
  assign tag  = cnt == CW'(BURST - 1);
  assign load = m_ready || !m_valid;
  // state register
  always_ff @(posedge CLK) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  // next state and pop request; pops only in RUN with data available and a free entry
  always_comb begin
    state_nx   = state;
    fifo_rd_en = 1'b0;
    state_nx   = fifo_empty ? IDLE : (state == IDLE) ? PRIME : RUN;
    fifo_rd_en = (state == RUN) && !fifo_empty && !sk_v && !rst;
  end
  // burst position of the next popped word
  always_ff @(posedge CLK) begin
    if (rst)             cnt <= '0;
    else if (fifo_rd_en) cnt <= tag ? '0 : cnt + CW'(1);
  end
  // output register refills from skid first, else from the FIFO; skid catches a pop while the output is held
  always_ff @(posedge CLK) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      sk_v    <= 1'b0;
      sk_d    <= '0;
      sk_l    <= 1'b0;
    end else if (load) begin
      m_valid <= sk_v || fifo_rd_en;
      m_data  <= sk_v ? sk_d : fifo_rd_en ? fifo_dout : m_data;
      m_last  <= sk_v ? sk_l : fifo_rd_en ? tag : m_last;
      sk_v    <= 1'b0;
    end else if (fifo_rd_en) begin
      sk_v <= 1'b1;
      sk_d <= fifo_dout;
      sk_l <= tag;
    end
  end
`ifdef FIFO_READER_CNT_EN
  // downstream transfer counter, wraps naturally at 16 bits
  always_ff @(posedge CLK) begin
    if (rst)                     rd_count <= '0;
    else if (m_valid && m_ready) rd_count <= rd_count + 16'd1;
  end
`endif
endmodule
